// File: rtl/std_linear_secded_stream_decoder.sv
// Streaming SECDED decoder: SEC-layout Hamming codeword plus an overall parity bit,
// behind a 1- or 2-stage valid/ready pipeline with saturating error counters.
module std_linear_secded_stream_decoder #(
    parameter int  P      = 4,
    parameter int  STAGES = 2,
    parameter int  CNT_W  = 16,
    localparam int N      = (1 << P) - 1 - P,
    localparam int K      = N + P
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [K:0]       i_codeword,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [N-1:0]     o_word,
    output logic [P-1:0]     o_syndrome,
    output logic             o_corrected,
    output logic             o_uncorrectable,
    input  logic             i_clear,
    output logic [CNT_W-1:0] o_cnt_corrected,
    output logic [CNT_W-1:0] o_cnt_uncorrectable
);

    // Codeword bit index of the j-th data bit: the non-power-of-two Hamming positions.
    function automatic int data_pos(int j);
        int cnt;
        cnt = 0;
        for (int i = 0; i < K; i++) begin
            if (((i + 1) & i) != 0) begin
                if (cnt == j) return i;
                cnt++;
            end
        end
        return 0;
    endfunction

    logic [P-1:0] in_syn;
    logic         in_q;
    logic [N-1:0] in_data;

    always_comb begin
        in_syn = '0;
        for (int i = 0; i < K; i++)
            if (i_codeword[i]) in_syn = in_syn ^ P'(i + 1);
        in_q = ^i_codeword;
        for (int j = 0; j < N; j++)
            in_data[j] = i_codeword[data_pos(j)];
    end

    logic [N-1:0] dec_data;
    logic [P-1:0] dec_syn;
    logic         dec_q;
    logic         dec_valid;
    logic         out_free;

    assign out_free = !o_valid || i_ready;

    generate
        if (STAGES == 2) begin : g_two
            logic         s1_valid;
            logic [N-1:0] s1_data;
            logic [P-1:0] s1_syn;
            logic         s1_q;

            // Stage 1 holds extracted data with its syndrome and parity check.
            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    s1_valid <= 1'b0;
                    s1_data  <= '0;
                    s1_syn   <= '0;
                    s1_q     <= 1'b0;
                end else if (o_ready) begin
                    s1_valid <= i_valid;
                    if (i_valid) begin
                        s1_data <= in_data;
                        s1_syn  <= in_syn;
                        s1_q    <= in_q;
                    end
                end
            end

            assign o_ready   = !s1_valid || out_free;
            assign dec_data  = s1_data;
            assign dec_syn   = s1_syn;
            assign dec_q     = s1_q;
            assign dec_valid = s1_valid;
        end else begin : g_one
            assign o_ready   = out_free;
            assign dec_data  = in_data;
            assign dec_syn   = in_syn;
            assign dec_q     = in_q;
            assign dec_valid = i_valid;
        end
    endgenerate

    logic [K-1:0] flip;
    logic [N-1:0] word;
    logic         corr;
    logic         unc;

    // A nonzero syndrome outside [1,K] matches no flip bit and is reported uncorrectable.
    always_comb begin
        flip = '0;
        for (int i = 0; i < K; i++)
            flip[i] = (dec_syn == P'(i + 1));
        for (int j = 0; j < N; j++)
            word[j] = dec_data[j] ^ (dec_q & flip[data_pos(j)]);
        corr = dec_q && ((dec_syn == '0) || (|flip));
        unc  = (dec_syn != '0) && !(dec_q && (|flip));
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_valid             <= 1'b0;
            o_word              <= '0;
            o_syndrome          <= '0;
            o_corrected         <= 1'b0;
            o_uncorrectable     <= 1'b0;
            o_cnt_corrected     <= '0;
            o_cnt_uncorrectable <= '0;
        end else begin
            if (out_free) o_valid <= dec_valid;
            if (out_free && dec_valid) begin
                o_word          <= word;
                o_syndrome      <= dec_syn;
                o_corrected     <= corr;
                o_uncorrectable <= unc;
            end
            // Clear wins over an increment landing on the same edge.
            if (i_clear) begin
                o_cnt_corrected     <= '0;
                o_cnt_uncorrectable <= '0;
            end else if (o_valid && i_ready) begin
                if (o_corrected && !(&o_cnt_corrected))
                    o_cnt_corrected <= o_cnt_corrected + 1'b1;
                if (o_uncorrectable && !(&o_cnt_uncorrectable))
                    o_cnt_uncorrectable <= o_cnt_uncorrectable + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_std_linear_secded_stream_decoder.sv
// Bench for std_linear_secded_stream_decoder: vector table, stall/clear/reset
// sequences and random streams on a STAGES=2 and a STAGES=1 instance.
`timescale 1ns/1ps
module tb_std_linear_secded_stream_decoder;
    localparam int P = 4;
    localparam int N = 11;
    localparam int K = 15;

    typedef struct packed {
        logic [N-1:0] w;
        logic [P-1:0] s;
        logic         c;
        logic         u;
    } res_t;

    typedef struct {
        logic [N-1:0] data;
        logic [K:0]   flip;
        res_t         exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       valid_in [2];
    logic       ready_in [2];
    logic       clear [2];
    logic [K:0] cw [2];
    logic       ready_out [2];
    logic       valid_out [2];
    logic       corr [2];
    logic       unc [2];
    logic [N-1:0] word [2];
    logic [P-1:0] syn [2];
    logic [1:0] cc [2];
    logic [1:0] cu [2];

    int   checks = 0;
    int   passed = 0;
    int   ndel [2] = '{0, 0};
    vec_t tbl [8];

    always #5 clk = ~clk;

    std_linear_secded_stream_decoder #(.P(P), .STAGES(2), .CNT_W(2)) dut2 (
        .i_clk(clk), .i_rst(rst), .i_valid(valid_in[0]), .o_ready(ready_out[0]),
        .i_codeword(cw[0]), .o_valid(valid_out[0]), .i_ready(ready_in[0]),
        .o_word(word[0]), .o_syndrome(syn[0]), .o_corrected(corr[0]),
        .o_uncorrectable(unc[0]), .i_clear(clear[0]),
        .o_cnt_corrected(cc[0]), .o_cnt_uncorrectable(cu[0])
    );

    std_linear_secded_stream_decoder #(.P(P), .STAGES(1), .CNT_W(2)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_valid(valid_in[1]), .o_ready(ready_out[1]),
        .i_codeword(cw[1]), .o_valid(valid_out[1]), .i_ready(ready_in[1]),
        .o_word(word[1]), .o_syndrome(syn[1]), .o_corrected(corr[1]),
        .o_uncorrectable(unc[1]), .i_clear(clear[1]),
        .o_cnt_corrected(cc[1]), .o_cnt_uncorrectable(cu[1])
    );

    function automatic int stg(int d);
        return (d == 0) ? 2 : 1;
    endfunction

    function automatic void chk(string name, int d, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s dut_stages=%0d: got %0h want %0h", name, stg(d), act, exp);
    endfunction

    // SEC encoder: data in non-power-of-two positions, even parity per check bit.
    function automatic logic [K:0] encode(logic [N-1:0] d);
        logic [K:0] c;
        int j;
        logic par;
        c = '0;
        j = 0;
        for (int pos = 1; pos <= K; pos++)
            if ($countones(pos) != 1) begin c[pos-1] = d[j]; j++; end
        for (int b = 0; b < P; b++) begin
            par = 1'b0;
            for (int pos = 1; pos <= K; pos++)
                if ((pos & (1 << b)) != 0 && $countones(pos) != 1) par = par ^ c[pos-1];
            c[(1 << b) - 1] = par;
        end
        c[K] = ^c[K-1:0];
        return c;
    endfunction

    function automatic res_t model(logic [K:0] c);
        res_t       r;
        int         s;
        int         j;
        logic       q;
        logic [K-1:0] f;
        s = 0;
        j = 0;
        q = ^c;
        f = c[K-1:0];
        for (int i = 0; i < K; i++) if (c[i]) s = s ^ (i + 1);
        r.c = 1'b0;
        r.u = 1'b0;
        if (q && s == 0) r.c = 1'b1;
        else if (q && s <= K) begin f[s-1] = ~f[s-1]; r.c = 1'b1; end
        else if (s != 0) r.u = 1'b1;
        r.s = P'(s);
        r.w = '0;
        for (int pos = 1; pos <= K; pos++)
            if ($countones(pos) != 1) begin r.w[j] = f[pos-1]; j++; end
        return r;
    endfunction

    function automatic logic [K:0] rand_err();
        logic [K:0] m;
        int nb;
        m = '0;
        nb = $urandom_range(0, 2);
        for (int b = 0; b < nb; b++) m[$urandom_range(0, K)] = 1'b1;
        return m;
    endfunction

    function automatic vec_t mk(logic [N-1:0] data, logic [K:0] flip, logic [N-1:0] w,
                                logic [P-1:0] s, logic c, logic u);
        vec_t v;
        v.data = data;
        v.flip = flip;
        v.exp  = {w, s, c, u};
        return v;
    endfunction

    // Per-instance scoreboard, occupancy-based ready check, stall check, counter model.
    for (genvar g = 0; g < 2; g++) begin : g_mon
        res_t exp_q[$];
        res_t held, cur, e;
        logic hold;
        int   ccm, cum;
        always @(negedge clk) begin
            cur = {word[g], syn[g], corr[g], unc[g]};
            if (rst) begin
                exp_q.delete();
                hold = 1'b0;
                ccm  = 0;
                cum  = 0;
            end else begin
                chk("cnt_corrected", g, 32'(cc[g]), 32'(ccm));
                chk("cnt_uncorrectable", g, 32'(cu[g]), 32'(cum));
                chk("ready", g, 32'(ready_out[g]), 32'(!(exp_q.size() == stg(g) && !ready_in[g])));
                if (hold) begin
                    chk("stall_valid", g, 32'(valid_out[g]), 32'd1);
                    chk("stall_payload", g, 32'(cur), 32'(held));
                end
                hold = valid_out[g] && !ready_in[g];
                held = cur;
                if (valid_out[g] && ready_in[g]) begin
                    chk("output_expected", g, 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        chk("sb_payload", g, 32'(cur), 32'(e));
                        ndel[g]++;
                        if (e.c && ccm < 3) ccm++;
                        if (e.u && cum < 3) cum++;
                    end
                end
                if (clear[g]) begin ccm = 0; cum = 0; end
                if (valid_in[g] && ready_out[g]) exp_q.push_back(model(cw[g]));
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic send(input int d, input logic [K:0] c);
        int n;
        n = 0;
        valid_in[d] = 1'b1;
        cw[d] = c;
        do begin @(negedge clk); n++; end while (!ready_out[d] && n < 100);
        chk("accept_timeout", d, 32'(ready_out[d]), 32'd1);
        @(posedge clk); #1;
        valid_in[d] = 1'b0;
    endtask

    task automatic wait_out(input int d, output int n);
        n = 0;
        do begin @(negedge clk); n++; end while (!valid_out[d] && n < 50);
        chk("out_timeout", d, 32'(valid_out[d]), 32'd1);
    endtask

    task automatic wait_del(input int d, input int tgt);
        int n;
        n = 0;
        while (ndel[d] < tgt && n < 300) begin @(negedge clk); n++; end
        chk("deliver_count", d, 32'(ndel[d]), 32'(tgt));
        @(posedge clk); #1;
    endtask

    task automatic run_all(input int d);
        int n, tgt;
        logic [K:0] c1;
        c1 = encode(tbl[1].data) ^ tbl[1].flip;

        foreach (tbl[i]) begin
            send(d, encode(tbl[i].data) ^ tbl[i].flip);
            wait_out(d, n);
            chk("latency", d, 32'(n), 32'(stg(d)));
            chk("tbl_result", d, 32'({word[d], syn[d], corr[d], unc[d]}), 32'(tbl[i].exp));
            @(posedge clk); #1;
        end
        chk("tbl_cnt_corr_sat", d, 32'(cc[d]), 32'd3);
        chk("tbl_cnt_unc", d, 32'(cu[d]), 32'd3);

        clear[d] = 1'b1;
        @(posedge clk); #1;
        clear[d] = 1'b0;
        chk("clear_corr", d, 32'(cc[d]), 32'd0);
        chk("clear_unc", d, 32'(cu[d]), 32'd0);

        tgt = ndel[d] + 5;
        for (int k = 0; k < 5; k++) send(d, c1);
        wait_del(d, tgt);
        chk("five_corr_sat", d, 32'(cc[d]), 32'd3);

        ready_in[d] = 1'b0;
        send(d, c1);
        wait_out(d, n);
        @(posedge clk); #1;
        ready_in[d] = 1'b1;
        clear[d] = 1'b1;
        @(posedge clk); #1;
        clear[d] = 1'b0;
        chk("clear_beats_inc", d, 32'(cc[d]), 32'd0);

        tgt = ndel[d] + 8;
        fork
            for (int k = 0; k < 8; k++) send(d, encode(N'($urandom)) ^ rand_err());
            begin
                for (int k = 0; k < 40; k++) begin
                    ready_in[d] = (k % 4 == 0) || (k % 4 == 3);
                    @(posedge clk); #1;
                end
                ready_in[d] = 1'b1;
            end
        join
        wait_del(d, tgt);

        tgt = ndel[d] + 40;
        fork
            for (int k = 0; k < 40; k++) begin
                repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                send(d, encode(N'($urandom)) ^ rand_err());
            end
            begin
                for (int k = 0; k < 150; k++) begin
                    ready_in[d] = ($urandom_range(0, 2) != 0);
                    @(posedge clk); #1;
                end
                ready_in[d] = 1'b1;
            end
        join
        wait_del(d, tgt);

        tgt = ndel[d] + 1;
        send(d, encode(11'h5A5) ^ 16'h0003);
        wait_del(d, tgt);
        ready_in[d] = 1'b0;
        for (int k = 0; k < stg(d); k++) send(d, encode(11'h5A5));
        rst = 1'b1;
        #1;
        chk("rst_valid", d, 32'(valid_out[d]), 32'd0);
        chk("rst_cnt_corr", d, 32'(cc[d]), 32'd0);
        chk("rst_cnt_unc", d, 32'(cu[d]), 32'd0);
        chk("rst_payload", d, 32'({word[d], syn[d], corr[d], unc[d]}), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        ready_in[d] = 1'b1;
        #1;
        chk("rst_ready", d, 32'(ready_out[d]), 32'd1);
        send(d, c1);
        wait_out(d, n);
        chk("post_rst_latency", d, 32'(n), 32'(stg(d)));
        chk("post_rst_result", d, 32'({word[d], syn[d], corr[d], unc[d]}), 32'(tbl[1].exp));
        @(posedge clk); #1;
    endtask

    initial begin
        tbl[0] = mk(11'h5A5, 16'h0000, 11'h5A5, 4'h0, 1'b0, 1'b0);
        tbl[1] = mk(11'h5A5, 16'h0008, 11'h5A5, 4'h4, 1'b1, 1'b0);
        tbl[2] = mk(11'h5A5, 16'h8000, 11'h5A5, 4'h0, 1'b1, 1'b0);
        tbl[3] = mk(11'h5A5, 16'h0003, 11'h5A5, 4'h3, 1'b0, 1'b1);
        tbl[4] = mk(11'h5A5, 16'h0004, 11'h5A5, 4'h3, 1'b1, 1'b0);
        tbl[5] = mk(11'h5A5, 16'h0014, 11'h5A6, 4'h6, 1'b0, 1'b1);
        tbl[6] = mk(11'h000, 16'h4000, 11'h000, 4'hF, 1'b1, 1'b0);
        tbl[7] = mk(11'h7FF, 16'hC000, 11'h3FF, 4'hF, 1'b0, 1'b1);
        for (int d = 0; d < 2; d++) begin
            valid_in[d] = 1'b0;
            ready_in[d] = 1'b1;
            clear[d]    = 1'b0;
            cw[d]       = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("reset_valid", d, 32'(valid_out[d]), 32'd0);
            chk("reset_payload", d, 32'({word[d], syn[d], corr[d], unc[d]}), 32'd0);
            chk("reset_cnt_corr", d, 32'(cc[d]), 32'd0);
            chk("reset_cnt_unc", d, 32'(cu[d]), 32'd0);
        end
        rst = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) chk("ready_after_reset", d, 32'(ready_out[d]), 32'd1);
        @(posedge clk); #1;
        for (int d = 0; d < 2; d++) run_all(d);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
